// File: rtl/rcv_ctrl_if.sv
// Bus bundle between the USB receive front end (bit sampler, shift register)
// and the receive control FSM.
interface rcv_ctrl_if;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;

  modport master (
    output d_edge, eop, shift_enable, rcv_data,
    input  rcving, w_enable, r_error
  );

  modport slave (
    input  d_edge, eop, shift_enable, rcv_data,
    output rcving, w_enable, r_error
  );
endinterface

// File: rtl/rcv_ctrl.sv
// USB-style receive control FSM: sync check, byte framing, FIFO write strobe, EOP/error tracking.
// Optional feature macro RCV_CTRL_BYTE_CNT_EN adds a saturating per-packet byte counter output.
module rcv_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  rcv_ctrl_if.slave  bus
`ifdef RCV_CTRL_BYTE_CNT_EN
  ,
  output logic [7:0] byte_cnt
`endif
);

  typedef enum logic [3:0] {
    IDLE,
    SYNC_RCV,
    CHK_SYNC,
    RCV_BYTE,
    STORE,
    EOP_DONE,
    ERR_WAIT,
    ERR_EOP,
    EIDLE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] bit_cnt;
  logic       sync_entry;
  logic       bit_shift;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.d_edge) next_state = SYNC_RCV;
      SYNC_RCV: begin
        if (bus.shift_enable) begin
          if (bus.eop)               next_state = ERR_EOP;
          else if (bit_cnt == 3'd7)  next_state = CHK_SYNC;
        end
      end
      CHK_SYNC: next_state = (bus.rcv_data == SYNC_BYTE) ? RCV_BYTE : ERR_WAIT;
      RCV_BYTE: begin
        // eop outranks byte completion: a byte cut short by EOP is never stored
        if (bus.shift_enable) begin
          if (bus.eop)               next_state = (bit_cnt == 3'd0) ? EOP_DONE : ERR_EOP;
          else if (bit_cnt == 3'd7)  next_state = STORE;
        end
      end
      STORE:    next_state = RCV_BYTE;
      EOP_DONE: if (bus.d_edge) next_state = IDLE;
      ERR_WAIT: if (bus.shift_enable && bus.eop) next_state = ERR_EOP;
      ERR_EOP:  if (bus.d_edge) next_state = EIDLE;
      EIDLE:    if (bus.d_edge) next_state = SYNC_RCV;
      default:  next_state = IDLE;
    endcase
  end

  assign sync_entry = (next_state == SYNC_RCV) && (state != SYNC_RCV);
  assign bit_shift  = bus.shift_enable && ((state == SYNC_RCV) || (state == RCV_BYTE));

  // NOTE: outputs are decoded from next_state and registered, so they are
  // glitch-free flops that still equal the Moore decode of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      bus.rcving   <= 1'b0;
      bus.w_enable <= 1'b0;
      bus.r_error  <= 1'b0;
    end else begin
      state <= next_state;
      if (sync_entry)
        bit_cnt <= 3'd0;
      else if (bit_shift)
        bit_cnt <= bit_cnt + 3'd1;
      bus.rcving   <= (next_state inside {SYNC_RCV, CHK_SYNC, RCV_BYTE, STORE,
                                          EOP_DONE, ERR_WAIT, ERR_EOP});
      bus.w_enable <= (next_state == STORE);
      bus.r_error  <= (next_state inside {ERR_WAIT, ERR_EOP, EIDLE});
    end
  end

`ifdef RCV_CTRL_BYTE_CNT_EN
  // Counts stored bytes of the current packet; held after EOP until the next packet.
  always_ff @(posedge clk) begin
    if (rst)
      byte_cnt <= 8'd0;
    else if (sync_entry)
      byte_cnt <= 8'd0;
    else if (bus.w_enable && (byte_cnt != 8'hFF))
      byte_cnt <= byte_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rcv_ctrl.sv
// Directed self-checking bench for rcv_ctrl; define RCV_CTRL_BYTE_CNT_EN to also
// cover the byte counter.
module tb_rcv_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] wq[$];

  rcv_ctrl_if bus();

`ifdef RCV_CTRL_BYTE_CNT_EN
  logic [7:0] byte_cnt;
  rcv_ctrl #(.SYNC_BYTE(8'h80)) dut (.clk(clk), .rst(rst), .bus(bus), .byte_cnt(byte_cnt));
`else
  rcv_ctrl #(.SYNC_BYTE(8'h80)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Log every FIFO write with the data present during the strobe
  always @(negedge clk) if (bus.w_enable === 1'b1) wq.push_back(bus.rcv_data);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_edge;
    bus.d_edge = 1'b1;
    tick();
    bus.d_edge = 1'b0;
  endtask

  task automatic shift(input logic e, input logic [7:0] d);
    bus.shift_enable = 1'b1;
    bus.eop          = e;
    bus.rcv_data     = d;
    tick();
    bus.shift_enable = 1'b0;
    bus.eop          = 1'b0;
  endtask

  // Eight bit strobes two cycles apart; the final byte value appears with the 8th
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      shift(1'b0, (i == 7) ? b : bus.rcv_data);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic cmp_out(input string name, input logic rcv, input logic we, input logic err);
    n_cmp++;
    if ({bus.rcving, bus.w_enable, bus.r_error} !== {rcv, we, err}) begin
      n_bad++;
      $display("FAIL %s: rcving/w_enable/r_error got %b%b%b want %b%b%b",
               name, bus.rcving, bus.w_enable, bus.r_error, rcv, we, err);
    end
  endtask

  task automatic test_reset;
    bus.d_edge = 1'b1; bus.shift_enable = 1'b1; bus.eop = 1'b1; bus.rcv_data = 8'h80;
    rst = 1'b1;
    tick();
    tick();
    cmp_out("reset_outputs", 1'b0, 1'b0, 1'b0);
    bus.d_edge = 1'b0;
    rst = 1'b0;
    shift(1'b1, 8'h00);
    tick();
    cmp_out("idle_ignores_shift", 1'b0, 1'b0, 1'b0);
`ifdef RCV_CTRL_BYTE_CNT_EN
    n_cmp++;
    if (byte_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt);
    end
`endif
  endtask

  task automatic good_packet(input string tag);
    wq.delete();
    pulse_edge();
    cmp_out({tag, "_sync_rcv"}, 1'b1, 1'b0, 1'b0);
    send_byte(8'h80);
    cmp_out({tag, "_chk_sync"}, 1'b1, 1'b0, 1'b0);
    tick();
    send_byte(8'hA5);
    cmp_out({tag, "_store_a5"}, 1'b1, 1'b1, 1'b0);
    tick();
    cmp_out({tag, "_after_store"}, 1'b1, 1'b0, 1'b0);
    send_byte(8'h3C);
    cmp_out({tag, "_store_3c"}, 1'b1, 1'b1, 1'b0);
    tick();
    shift(1'b1, 8'h3C);
    cmp_out({tag, "_eop_done"}, 1'b1, 1'b0, 1'b0);
    tick();
    pulse_edge();
    cmp_out({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (wq.size() !== 2) begin
      n_bad++;
      $display("FAIL %s_write_count: got %0d want 2", tag, wq.size());
    end else begin
      n_cmp++;
      if (wq[0] !== 8'hA5 || wq[1] !== 8'h3C) begin
        n_bad++;
        $display("FAIL %s_write_data: got %h %h want a5 3c", tag, wq[0], wq[1]);
      end
    end
`ifdef RCV_CTRL_BYTE_CNT_EN
    n_cmp++;
    if (byte_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL %s_byte_cnt: got %0d want 2", tag, byte_cnt);
    end
`endif
  endtask

  task automatic test_bad_sync;
    do_reset();
    pulse_edge();
    send_byte(8'h81);
    cmp_out("bad_sync_chk", 1'b1, 1'b0, 1'b0);
    tick();
    cmp_out("bad_sync_err_wait", 1'b1, 1'b0, 1'b1);
    shift(1'b0, 8'h00);
    tick();
    cmp_out("err_wait_holds", 1'b1, 1'b0, 1'b1);
    shift(1'b1, 8'h00);
    cmp_out("err_wait_eop", 1'b1, 1'b0, 1'b1);
    tick();
    pulse_edge();
    cmp_out("eidle", 1'b0, 1'b0, 1'b1);
    tick();
    pulse_edge();
    cmp_out("eidle_restart", 1'b1, 1'b0, 1'b0);
    send_byte(8'h80);
    tick();
    shift(1'b1, 8'h80);
    cmp_out("restart_eop_done", 1'b1, 1'b0, 1'b0);
    pulse_edge();
    cmp_out("restart_idle", 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (wq.size() !== 0) begin
      n_bad++;
      $display("FAIL bad_sync_writes: got %0d want 0", wq.size());
    end
  endtask

  task automatic test_eop_errors;
    // eop during sync
    do_reset();
    pulse_edge();
    shift(1'b0, 8'h00);
    tick();
    shift(1'b1, 8'h00);
    cmp_out("sync_eop_err", 1'b1, 1'b0, 1'b1);
    // eop after three data bits
    do_reset();
    pulse_edge();
    send_byte(8'h80);
    tick();
    for (int i = 0; i < 3; i++) begin
      shift(1'b0, 8'h80);
      tick();
    end
    shift(1'b1, 8'h80);
    cmp_out("partial_byte_eop", 1'b1, 1'b0, 1'b1);
    tick();
    cmp_out("partial_byte_hold", 1'b1, 1'b0, 1'b1);
    // eop on the 8th bit of a byte
    pulse_edge();
    pulse_edge();
    send_byte(8'h80);
    tick();
    for (int i = 0; i < 7; i++) begin
      shift(1'b0, 8'h80);
      tick();
    end
    shift(1'b1, 8'h5A);
    cmp_out("eop_on_bit8", 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    cmp_out("eop_on_bit8_hold", 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (wq.size() !== 0) begin
      n_bad++;
      $display("FAIL eop_error_writes: got %0d want 0", wq.size());
    end
  endtask

  task automatic test_ignored_edge;
    do_reset();
    pulse_edge();
    send_byte(8'h80);
    tick();
    for (int i = 0; i < 4; i++) begin
      shift(1'b0, 8'h00);
      tick();
    end
    pulse_edge();
    cmp_out("edge_in_rcv_byte", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      shift(1'b0, (i == 3) ? 8'h5A : 8'h00);
    end
    cmp_out("edge_ignored_store", 1'b1, 1'b1, 1'b0);
    tick();
    shift(1'b1, 8'h5A);
    pulse_edge();
    cmp_out("edge_ignored_idle", 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (wq.size() !== 1 || wq[0] !== 8'h5A) begin
      n_bad++;
      $display("FAIL edge_ignored_data: got %0d writes want one of 5a", wq.size());
    end
  endtask

  task automatic test_reset_in_store;
    int n;
    do_reset();
    pulse_edge();
    send_byte(8'h80);
    tick();
    send_byte(8'h77);
    cmp_out("pre_reset_store", 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    cmp_out("reset_in_store", 1'b0, 1'b0, 1'b0);
    n = wq.size();
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (n !== 1 || wq.size() !== 1) begin
      n_bad++;
      $display("FAIL reset_store_writes: got %0d/%0d want 1/1", n, wq.size());
    end
`ifdef RCV_CTRL_BYTE_CNT_EN
    n_cmp++;
    if (byte_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_store_byte_cnt: got %0d want 0", byte_cnt);
    end
`endif
    good_packet("post_reset");
  endtask

`ifdef RCV_CTRL_BYTE_CNT_EN
  task automatic test_saturation;
    logic [7:0] b;
    do_reset();
    pulse_edge();
    send_byte(8'h80);
    tick();
    for (int i = 0; i < 300; i++) begin
      b = 8'(i);
      send_byte(b);
      tick();
    end
    shift(1'b1, 8'h00);
    tick();
    pulse_edge();
    cmp_out("sat_idle", 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (byte_cnt !== 8'hFF || wq.size() !== 300) begin
      n_bad++;
      $display("FAIL byte_cnt_saturate: got %0d (%0d writes) want 255 (300 writes)",
               byte_cnt, wq.size());
    end
  endtask
`endif

  initial begin
    bus.d_edge = 1'b0; bus.eop = 1'b0; bus.shift_enable = 1'b0; bus.rcv_data = 8'h00;
    rst = 1'b1;
    test_reset();
    good_packet("good");
    good_packet("back_to_back");
    test_bad_sync();
    test_eop_errors();
    test_ignored_edge();
    test_reset_in_store();
`ifdef RCV_CTRL_BYTE_CNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
